// File: rtl/mcpu_mio_bridge_if.sv
// CPU-side request/ready bus between the MCPU core and the memory/IO bridge.
// The bridge holds no request queue: the CPU keeps CPU_MIO high until MIO_ready pulses.
interface mcpu_mio_bridge_if;
    logic        CPU_MIO;
    logic        mem_w;
    logic [31:0] addr_bus;
    logic [31:0] Data_out;
    logic        MIO_ready;
    logic [31:0] Data_in;

    modport master (
        output CPU_MIO, mem_w, addr_bus, Data_out,
        input  MIO_ready, Data_in
    );

    modport slave (
        input  CPU_MIO, mem_w, addr_bus, Data_out,
        output MIO_ready, Data_in
    );
endinterface

// File: rtl/mcpu_mio_bridge.sv
// MCPU memory/IO bridge: RAM, LED and switch decode; 1 cycle (RAM read RAM_WAIT+1) to MIO_ready,
// CPU is stalled by holding MIO_ready low. Optional free-running timer at 0xF000_0004 via MIO_TIMER_EN.
module mcpu_mio_bridge #(
    parameter int RAM_WAIT = 1,
    parameter int RAM_AW   = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    mcpu_mio_bridge_if.slave  bus,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    input  logic [15:0]       sw_in,
    output logic [15:0]       led_out,
    output logic              bus_err
);

    typedef enum logic [1:0] {IDLE, RWAIT, DONE} state_e;

    localparam logic [3:0] WAIT_LAST = 4'(RAM_WAIT - 1);

    state_e              state_q, state_d;
    logic [3:0]          wait_q, wait_d;
    logic                we_q, we_d;
    logic [RAM_AW-1:0]   addr_q, addr_d;
    logic [31:0]         wdat_q, wdat_d;
    logic [31:0]         data_in_q, data_in_d;
    logic [15:0]         led_q, led_d;
    logic                err_q, err_d;

    logic hit_ram, hit_led, hit_sw;

    assign hit_ram = (bus.addr_bus[31:28] == 4'h0);
    assign hit_led = (bus.addr_bus == 32'hE000_0000);
    assign hit_sw  = (bus.addr_bus == 32'hF000_0000);

`ifdef MIO_TIMER_EN
    logic [31:0] timer_q, timer_d;
    logic        hit_tmr;

    assign hit_tmr = (bus.addr_bus == 32'hF000_0004);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            wait_q    <= 4'd0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdat_q    <= 32'd0;
            data_in_q <= 32'd0;
            led_q     <= 16'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdat_q    <= wdat_d;
            data_in_q <= data_in_d;
            led_q     <= led_d;
            err_q     <= err_d;
        end
    end

`ifdef MIO_TIMER_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) timer_q <= 32'd0;
        else          timer_q <= timer_d;
    end
`endif

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdat_d    = wdat_q;
        data_in_d = data_in_q;
        led_d     = led_q;
        err_d     = err_q;
        ram_we    = 1'b0;
        ram_addr  = addr_q;
        ram_din   = wdat_q;
`ifdef MIO_TIMER_EN
        timer_d   = timer_q + 32'd1;
`endif

        case (state_q)
            IDLE: begin
                // RAM writes complete in the accepting cycle, so the RAM sees the live bus here.
                ram_addr = bus.addr_bus[RAM_AW+1:2];
                ram_din  = bus.Data_out;
                if (bus.CPU_MIO) begin
                    we_d    = bus.mem_w;
                    addr_d  = bus.addr_bus[RAM_AW+1:2];
                    wdat_d  = bus.Data_out;
                    wait_d  = 4'd0;
                    state_d = DONE;
                    if (hit_ram) begin
                        if (bus.mem_w) ram_we  = reset_n;
                        else           state_d = RWAIT;
                    end else if (hit_led) begin
                        if (bus.mem_w) led_d     = bus.Data_out[15:0];
                        else           data_in_d = {16'd0, led_q};
                    end else if (hit_sw) begin
                        if (!bus.mem_w) data_in_d = {16'd0, sw_in};
                    end
`ifdef MIO_TIMER_EN
                    else if (hit_tmr) begin
                        if (bus.mem_w) timer_d   = bus.Data_out;
                        else           data_in_d = timer_q;
                    end
`endif
                    else begin
                        err_d = 1'b1;
                        if (!bus.mem_w) data_in_d = 32'd0;
                    end
                end
            end
            RWAIT: begin
                if (wait_q == WAIT_LAST) begin
                    if (!we_q) data_in_d = ram_dout;
                    wait_d  = 4'd0;
                    state_d = DONE;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.MIO_ready = (state_q == DONE);
    assign bus.Data_in   = data_in_q;
    assign led_out       = led_q;
    assign bus_err       = err_q;

endmodule
